// File: rtl/ex_branch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_branch_stage
//  Description : Execute-stage back end. Resolves conditional branches and
//                JAL/JALR from the ALU result and flags. Issues a one-cycle
//                PC redirect and drops a fixed number of wrong-path beats
//                after it. Surviving beats go to the EX/MEM interface through
//                a 2-entry skid buffer with valid/ready handshaking.
//                Optional feature: define MISALIGN_TRAP_EN to add out_trap.
//                A misaligned taken target then raises a trap instead of
//                redirecting.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_branch_stage #(
  parameter int          SQUASH_DEPTH = 2,      // wrong-path accepts to drop (1..7)
  parameter logic [31:0] RESET_PC     = 32'h0   // reset value of redirect_pc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_imm,
  input  logic [2:0]  in_funct3,
  input  logic        in_is_branch,
  input  logic        in_is_jal,
  input  logic        in_is_jalr,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        out_trap
`endif
);

  localparam logic [2:0] c_SQUASH_DEPTH = 3'(SQUASH_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_sq_cnt;
  logic [2:0]  w_sq_cnt_nxt;

  logic        w_accept;
  logic        w_cond;
  logic        w_taken;
  logic        w_trap;
  logic        w_drop;
  logic        w_redirect;
  logic        w_push;
  logic [31:0] w_link;
  logic [31:0] w_target;
  logic [31:0] w_beat_result;
  logic        w_beat_rw;

  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;

  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic [4:0]  r_out_rd;
  logic        r_out_rw;
  logic        r_skid_valid;
  logic [31:0] r_skid_result;
  logic [4:0]  r_skid_rd;
  logic        r_skid_rw;

  // A new beat can only enter while the skid slot is free.
  assign in_ready = ~r_skid_valid;
  assign w_accept = in_valid & in_ready;

  // Branch condition from the SUB flags of rs1 - rs2.
  always_comb begin
    w_cond = 1'b0;
    case (in_funct3)
      3'b000:  w_cond = alu_zero;
      3'b001:  w_cond = ~alu_zero;
      3'b100:  w_cond = alu_sign ^ alu_overflow;
      3'b101:  w_cond = ~(alu_sign ^ alu_overflow);
      3'b110:  w_cond = alu_carry;
      3'b111:  w_cond = ~alu_carry;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken  = in_is_jal | in_is_jalr | (in_is_branch & w_cond);
  assign w_link   = in_pc + 32'd4;
  assign w_target = in_is_jalr ? (alu_out & ~32'h1) : (in_pc + in_imm);

`ifdef MISALIGN_TRAP_EN
  assign w_trap = w_taken & (w_target[1:0] != 2'b00);
`else
  assign w_trap = 1'b0;
`endif

  // A trapping beat carries its target as the result and never writes rd.
  assign w_beat_result = w_trap ? w_target
                       : ((in_is_jal | in_is_jalr) ? w_link : alu_out);
  assign w_beat_rw     = in_reg_write & (in_rd != 5'd0) & ~w_trap;

  // Next-state logic: redirect from RUN, count dropped accepts in SQUASH.
  always_comb begin
    w_state_nxt  = r_state;
    w_sq_cnt_nxt = r_sq_cnt;
    w_drop       = 1'b0;
    w_redirect   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_accept & w_taken & ~w_trap) begin
          w_redirect   = 1'b1;
          w_state_nxt  = ST_SQUASH;
          w_sq_cnt_nxt = c_SQUASH_DEPTH;
        end
      end
      ST_SQUASH: begin
        if (w_accept) begin
          w_drop       = 1'b1;
          w_sq_cnt_nxt = r_sq_cnt - 3'd1;
          if (r_sq_cnt == 3'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_RUN;
        w_sq_cnt_nxt = 3'd0;
      end
    endcase
  end

  assign w_push = w_accept & ~w_drop;

  // State register and squash counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_sq_cnt <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
    end
  end

  // One-cycle redirect pulse; the target holds until the next redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= RESET_PC;
    end else begin
      r_redirect_valid <= w_redirect;
      if (w_redirect) begin
        r_redirect_pc <= w_target;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_out_trap;
  logic r_skid_trap;
`endif

  // Output register plus skid slot: the skid catches one beat while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= 32'd0;
      r_out_rd      <= 5'd0;
      r_out_rw      <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_result <= 32'd0;
      r_skid_rd     <= 5'd0;
      r_skid_rw     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_out_trap    <= 1'b0;
      r_skid_trap   <= 1'b0;
`endif
    end else if (~r_out_valid | out_ready) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_result <= r_skid_result;
        r_out_rd     <= r_skid_rd;
        r_out_rw     <= r_skid_rw;
        r_skid_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
        r_out_trap   <= r_skid_trap;
`endif
      end else if (w_push) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_beat_result;
        r_out_rd     <= in_rd;
        r_out_rw     <= w_beat_rw;
`ifdef MISALIGN_TRAP_EN
        r_out_trap   <= w_trap;
`endif
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_push) begin
      r_skid_valid  <= 1'b1;
      r_skid_result <= w_beat_result;
      r_skid_rd     <= in_rd;
      r_skid_rw     <= w_beat_rw;
`ifdef MISALIGN_TRAP_EN
      r_skid_trap   <= w_trap;
`endif
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_out_result;
  assign out_rd         = r_out_rd;
  assign out_reg_write  = r_out_rw;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
`ifdef MISALIGN_TRAP_EN
  assign out_trap       = r_out_trap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_branch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_branch_stage
//  Description : Self-checking bench for ex_branch_stage. Directed scenarios
//                and randomized beats are checked by a scoreboard fed from
//                a behavioural model that works on rs1/rs2 operand values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_branch_stage;

  localparam int          SQ  = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_imm = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_is_branch = 1'b0;
  logic        in_is_jal = 1'b0;
  logic        in_is_jalr = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic [31:0] alu_out = '0;
  logic        alu_zero = 1'b0;
  logic        alu_carry = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        alu_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef MISALIGN_TRAP_EN
  logic        out_trap;
`endif

  ex_branch_stage #(.SQUASH_DEPTH(SQ), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_funct3(in_funct3),
    .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_sign(alu_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef MISALIGN_TRAP_EN
    , .out_trap(out_trap)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operands the ALU was notionally driven with, used by the model.
  logic [31:0] cur_rs1 = '0;
  logic [31:0] cur_rs2 = '0;

  typedef struct { logic [31:0] res; logic [4:0] rd; logic rw; logic trap; } beat_t;
  typedef struct { int cyc; logic [31:0] pc; } redir_t;
  beat_t  exp_q[$];
  redir_t red_q[$];

  // Reference model: decides each accepted beat's fate from operand values.
  int sq_left = 0;
  always @(negedge clk) begin
    logic        taken, trap, link;
    logic [31:0] target, res;
    if (rst) begin
      exp_q.delete();
      red_q.delete();
      sq_left = 0;
    end else if (in_valid && in_ready) begin
      if (sq_left > 0) begin
        sq_left--;
      end else begin
        taken = 1'b0;
        if (in_is_jal || in_is_jalr) taken = 1'b1;
        else if (in_is_branch) begin
          case (in_funct3)
            3'd0: taken = (cur_rs1 == cur_rs2);
            3'd1: taken = (cur_rs1 != cur_rs2);
            3'd4: taken = ($signed(cur_rs1) <  $signed(cur_rs2));
            3'd5: taken = ($signed(cur_rs1) >= $signed(cur_rs2));
            3'd6: taken = (cur_rs1 <  cur_rs2);
            3'd7: taken = (cur_rs1 >= cur_rs2);
            default: taken = 1'b0;
          endcase
        end
        target = in_is_jalr ? {alu_out[31:1], 1'b0} : in_pc + in_imm;
`ifdef MISALIGN_TRAP_EN
        trap = taken && (target % 4 != 0);
`else
        trap = 1'b0;
`endif
        link = in_is_jal || in_is_jalr;
        res  = trap ? target : (link ? in_pc + 32'd4 : alu_out);
        exp_q.push_back('{res: res, rd: in_rd,
                          rw: in_reg_write && (in_rd != 0) && !trap, trap: trap});
        if (taken && !trap) begin
          red_q.push_back('{cyc: cyc + 1, pc: target});
          sq_left = SQ;
        end
      end
    end
  end

  // Monitor: redirect timing every cycle, output beats on each handshake.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (red_q.size() > 0 && red_q[0].cyc == cyc) begin
        chk("redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("redirect_pc", redirect_pc, red_q[0].pc);
        void'(red_q.pop_front());
      end else begin
        chk("redirect_idle", {31'd0, redirect_valid}, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_result, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
          chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
`ifdef MISALIGN_TRAP_EN
          chk("out_trap", {31'd0, out_trap}, {31'd0, e.trap});
`endif
        end
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = stalled, 2 = random.
  int mode = 0;
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom % 4) != 0;
    endcase
  end

  // Kind: 0 ALU op, 1 conditional branch, 2 JAL, 3 JALR.
  task automatic set_beat(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                          input int kind, input logic [4:0] rd, input logic rw,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] alu);
    logic [31:0] diff;
    in_pc = pc; in_imm = imm; in_funct3 = f3; in_rd = rd; in_reg_write = rw;
    in_is_branch = (kind == 1); in_is_jal = (kind == 2); in_is_jalr = (kind == 3);
    cur_rs1 = rs1; cur_rs2 = rs2;
    if (kind == 1) begin
      diff         = rs1 - rs2;
      alu_out      = diff;
      alu_zero     = (diff == 0);
      alu_carry    = (rs1 < rs2);
      alu_sign     = diff[31];
      alu_overflow = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);
    end else begin
      alu_out      = alu;
      alu_zero     = $urandom % 2;
      alu_carry    = $urandom % 2;
      alu_sign     = $urandom % 2;
      alu_overflow = $urandom % 2;
    end
  endtask

  task automatic handshake();
    bit done = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout actual=in_ready_low expected=accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                      input int kind, input logic [4:0] rd, input logic rw,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] alu);
    set_beat(pc, imm, f3, kind, rd, rw, rs1, rs2, alu);
    handshake();
  endtask

  task automatic send_alu(input logic [31:0] v);
    send(32'h1000, 32'h0, 3'd0, 0, 5'd3, 1'b1, 32'h0, 32'h0, v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_random();
    logic [31:0] t, rs1, rs2;
    int kind;
    t    = $urandom;
    rs1  = $urandom;
    rs2  = ($urandom % 3 == 0) ? rs1 : $urandom;
    kind = $urandom % 8;
    if (kind > 3) kind = 0;
    send($urandom & 32'hFFFF_FFFC, {{20{t[11]}}, t[11:1], 1'b0}, 3'($urandom),
         kind, 5'($urandom), 1'($urandom), rs1, rs2, $urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, RPC);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_out_rd", {27'd0, out_rd}, 32'd0);
    chk("reset_out_reg_write", {31'd0, out_reg_write}, 32'd0);
    @(posedge clk); #1;

    // BEQ taken, then two dropped beats and one survivor.
    send(32'h100, 32'h20, 3'd0, 1, 5'd0, 1'b0, 32'h5, 32'h5, 32'h0);
    send_alu(32'hA1); send_alu(32'hA2); send_alu(32'hA3);
    // BLT not taken (sign=1, overflow=1), BLTU taken backwards.
    send(32'h80, 32'h40, 3'd4, 1, 5'd0, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    send(32'h40, 32'hFFFF_FFF8, 3'd6, 1, 5'd0, 1'b0, 32'h1, 32'h2, 32'h0);
    send_alu(32'hB1); send_alu(32'hB2); send_alu(32'hB3);
    // JALR link and cleared bit 0.
    send(32'h200, 32'h3, 3'd0, 3, 5'd1, 1'b1, 32'h0, 32'h0, 32'h1003);
    send_alu(32'hC1); send_alu(32'hC2); send_alu(32'hC3);
    // JAL to a misaligned target.
    send(32'h10, 32'h6, 3'd0, 2, 5'd1, 1'b1, 32'h0, 32'h0, 32'h0);
    send_alu(32'hD1); send_alu(32'hD2); send_alu(32'hD3);
    // funct3 010 is never taken even with equal operands.
    send(32'h300, 32'h10, 3'd2, 1, 5'd2, 1'b1, 32'h9, 32'h9, 32'h0);

    // Stall: two beats captured, third held back, then drained in order.
    mode = 1; @(posedge clk); #1;
    send_alu(32'hE1); send_alu(32'hE2);
    set_beat(32'h0, 32'h0, 3'd0, 0, 5'd4, 1'b1, 32'h0, 32'h0, 32'hE3);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_out_hold", out_result, 32'hE1);
    mode = 0;
    handshake();
    repeat (4) @(posedge clk); #1;

    // Reset with skid full and a squash pending.
    mode = 1; @(posedge clk); #1;
    send_alu(32'hF1);
    send(32'h500, 32'h40, 3'd0, 1, 5'd0, 1'b0, 32'h7, 32'h7, 32'h0);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    mode = 0;
    @(posedge clk); #1;
    send_alu(32'hF2);
    repeat (3) @(posedge clk); #1;

    // Randomized traffic with random backpressure and idle gaps.
    mode = 2;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom % 5 == 0) begin
        @(posedge clk); #1;
      end
      send_random();
    end

    mode = 0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_beats_left", exp_q.size(), 32'd0);
    chk("drain_redirects_left", red_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
